// File: rtl/fir_out_fifo.sv
`default_nettype none
// fir_out_fifo: AXI-Stream elastic buffer behind the FIR core, carrying tlast per beat and
// reporting occupancy and frame completion. Define FIR_OUT_FIFO_STATS_EN for statistics outputs.
module fir_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int AW          = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [AW:0]            level,
  output logic                   frame_done
`ifdef FIR_OUT_FIFO_STATS_EN
  ,
  output logic [31:0]            beat_cnt,
  output logic [15:0]            frame_cnt,
  output logic [AW:0]            hwm
`endif
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [pDATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          level_r;
  logic [AW:0]          level_nxt;
  logic                 frame_done_r;
  logic                 push;
  logic                 pop;

  // Handshake outputs depend only on registered occupancy, so no comb path crosses the buffer.
  assign s_tready   = (level_r != FULL_LEVEL);
  assign m_tvalid   = (level_r != '0);
  assign push       = s_tvalid & s_tready;
  assign pop        = m_tvalid & m_tready;
  assign m_tdata    = mem[rd_ptr][pDATA_WIDTH-1:0];
  assign m_tlast    = mem[rd_ptr][pDATA_WIDTH];
  assign level      = level_r;
  assign frame_done = frame_done_r;

  always_comb begin
    level_nxt = level_r;
    if (push && !pop) begin
      level_nxt = level_r + LEVEL_ONE;
    end else if (pop && !push) begin
      level_nxt = level_r - LEVEL_ONE;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_r      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level_r      <= level_nxt;
      frame_done_r <= pop & m_tlast;
    end
  end

`ifdef FIR_OUT_FIFO_STATS_EN
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
      hwm       <= '0;
    end else begin
      if (pop) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (pop && m_tlast) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (level_nxt > hwm) begin
        hwm <= level_nxt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_out_fifo.sv
`default_nettype none
// tb_fir_out_fifo: directed and randomized checks of fir_out_fifo against a queue-based reference.
module tb_fir_out_fifo;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [AW:0]   level;
  logic          frame_done;
`ifdef FIR_OUT_FIFO_STATS_EN
  logic [31:0]   beat_cnt;
  logic [15:0]   frame_cnt;
  logic [AW:0]   hwm;
`endif

  fir_out_fifo #(.pDATA_WIDTH(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .level      (level),
    .frame_done (frame_done)
`ifdef FIR_OUT_FIFO_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .frame_cnt  (frame_cnt),
    .hwm        (hwm)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [W:0] q[$];
  logic [W:0] popped_log[$];
  logic [W:0] sent_log[$];
  logic       exp_fd = 1'b0;
  int         fd_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check all outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r,
                       output logic acc);
    logic       do_push;
    logic       do_pop;
    logic [W:0] b;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    @(negedge axis_clk);
    chk("level", 64'(level), 64'(q.size()));
    chk("s_tready", 64'(s_tready), 64'(q.size() != DEPTH));
    chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) chk("m_beat", 64'({m_tlast, m_tdata}), 64'(q[0]));
    chk("frame_done", 64'(frame_done), 64'(exp_fd));
    if (frame_done === 1'b1) fd_seen++;
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    @(posedge axis_clk);
    exp_fd = 1'b0;
    if (do_pop) begin
      b = q.pop_front();
      popped_log.push_back(b);
      exp_fd = b[W];
    end
    if (do_push) begin
      q.push_back({l, d});
      sent_log.push_back({l, d});
    end
    acc = do_push;
    #1;
  endtask

  task automatic do_reset();
    axis_rst_n = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
`ifdef FIR_OUT_FIFO_STATS_EN
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_hwm", 64'(hwm), 64'd0);
`endif
    q.delete();
    exp_fd = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int   guard = 0;
    while (q.size() != 0 && guard < 60) begin
      cycle(1'b0, '0, 1'b0, 1'b1, acc);
      guard++;
    end
    chk("drain_bound", 64'(guard < 60), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic clear_logs();
    popped_log.delete();
    sent_log.delete();
    fd_seen = 0;
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_count"}, 64'(popped_log.size()), 64'(sent_log.size()));
    for (int i = 0; i < popped_log.size() && i < sent_log.size(); i++)
      chk({tag, "_beat"}, 64'(popped_log[i]), 64'(sent_log[i]));
  endtask

  // Backpressure scenario: 20 beats offered against a stalled consumer, then released.
  task automatic run_stall20();
    logic [W-1:0] dat [20];
    logic         acc;
    int           idx = 0;
    int           guard = 0;
    for (int i = 0; i < 20; i++) dat[i] = $urandom;
    repeat (20) begin
      cycle(1'b1, dat[idx], idx == 19, 1'b0, acc);
      if (acc) idx++;
    end
    chk("t3_accepted", 64'(idx), 64'd16);
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_s_tready", 64'(s_tready), 64'd0);
    while (idx < 20 && guard < 100) begin
      cycle(1'b1, dat[idx], idx == 19, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    chk("t3_bound", 64'(guard < 100), 64'd1);
    drain();
    chk("t3_count", 64'(popped_log.size()), 64'd20);
    for (int i = 0; i < popped_log.size() && i < 20; i++)
      chk("t3_beat", 64'(popped_log[i]), 64'({i == 19, dat[i]}));
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] d;
    logic         l;
    logic         v;
    int           guard;

    // Test 1: reset state
    #2;
    do_reset();

    // Test 2: 600-beat frame at full rate
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, W'(i), i == 599, 1'b1, acc);
      chk("t2_level_le1", 64'(level <= 1), 64'd1);
    end
    drain();
    chk("t2_count", 64'(popped_log.size()), 64'd600);
    for (int i = 0; i < popped_log.size() && i < 600; i++)
      chk("t2_beat", 64'(popped_log[i]), 64'({i == 599, W'(i)}));
    chk("t2_fd_pulses", 64'(fd_seen), 64'd1);

    // Test 3: fill to full under backpressure
    clear_logs();
    run_stall20();

    // Test 4: steady-state push+pop at level 8 across pointer wrap
    clear_logs();
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, acc);
    chk("t4_level8", 64'(level), 64'd8);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, i == 9, 1'b1, acc);
      chk("t4_level_hold", 64'(level), 64'd8);
    end
    drain();
    check_order("t4");
    chk("t4_fd_pulses", 64'(fd_seen), 64'd1);

    // Test 5: reset mid-frame, then a clean 3-beat frame
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, acc);
    chk("t5_level5", 64'(level), 64'd5);
    do_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'hA0 + i), i == 2, 1'b1, acc);
    drain();
    chk("t5_count", 64'(popped_log.size()), 64'd3);
    check_order("t5");
    chk("t5_fd_pulses", 64'(fd_seen), 64'd1);

    // Randomized traffic with held beats while stalled
    clear_logs();
    d = $urandom; l = ($urandom_range(7) == 0); v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!v) v = ($urandom_range(3) != 0);
      cycle(v, d, l, $urandom_range(2) != 0, acc);
      if (acc) begin
        d = $urandom; l = ($urandom_range(7) == 0); v = 1'b0;
      end
    end
    drain();
    check_order("rand");

`ifdef FIR_OUT_FIFO_STATS_EN
    // Test 6: statistics after the stall scenario
    do_reset();
    clear_logs();
    run_stall20();
    chk("t6_beat_cnt", 64'(beat_cnt), 64'd20);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_hwm", 64'(hwm), 64'd16);
`endif

    guard = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
